multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Parametrised multi-cycle control unit for the RV64 core; supersedes the single-opcode combinational decoder.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over R, I, load, store, branch and optional word (*W) opcodes.
- Drives instruction/data memory request-ready handshakes with a bounded wait timeout.
- Raises a sticky trap on an illegal opcode or a memory timeout.

Parameters:
- SUPPORT_WORD_OPS, default 1, meaning: 1 accepts OP-32 (0111011) and OP-IMM-32 (0011011); 0 treats them as illegal.
- TIMEOUT_CYCLES, default 16, meaning: maximum cycles spent waiting for a ready in FETCH or MEM; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- opcode  in  7  instr[6:0] from the instruction register; sampled in DECODE.
- imem_ready  in  1  instruction memory has delivered the word.
- dmem_ready  in  1  data access complete.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data write (store).
- ir_write  out  1  latch the fetched instruction.
- pc_write  out  1  PC <= PC+4.
- RegWrite  out  1  register file write enable.
- ALUOp  out  2  00 add (address), 01 branch compare, 10 funct-decoded, 11 invalid.
- ALUSrc  out  1  0 = rs2, 1 = immediate.
- MemToReg  out  1  writeback selects load data.
- word_op  out  1  current instruction is a 32-bit *W op.
- branch  out  1  branch-resolve strobe.
- illegal  out  1  sticky: illegal opcode trap.
- mem_timeout  out  1  sticky: handshake timeout trap.
- state_o  out  3  current state (debug).

Behaviour:
- Reset: state=FETCH, class register cleared, wait counter=0. All 1-bit outputs read 0 during reset, ALUOp=11, and both sticky flags clear. The first post-reset cycle is FETCH, with imem_req=1.
- Encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5.
- Outputs are decoded combinationally from the registered state, the latched class and the ready inputs.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1 and pc_write=1 in that same cycle, then -> DECODE.
- DECODE:
  - Classify opcode and latch class and word_op.
  - Classes and opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, R32 0111011, I32 0011011.
  - Any other opcode, or R32/I32 when SUPPORT_WORD_OPS=0 -> TRAP with illegal=1.
  - Otherwise -> EXECUTE.
- EXECUTE, by class:
  - R/R32: ALUOp=10, ALUSrc=0, then -> WRITEBACK.
  - I/I32: ALUOp=10, ALUSrc=1, then -> WRITEBACK.
  - LOAD/STORE: ALUOp=00, ALUSrc=1, then -> MEM.
  - BRANCH: ALUOp=01, ALUSrc=0, branch=1 for this cycle only, then -> FETCH.
- MEM:
  - dmem_req=1; dmem_we=1 only for STORE; ALUOp holds 00.
  - On dmem_ready: LOAD -> WRITEBACK, STORE -> FETCH.
- WRITEBACK:
  - RegWrite=1 for exactly one cycle; MemToReg=1 for LOAD only.
  - Then -> FETCH.
- TRAP:
  - All requests and write enables are 0, ALUOp=11.
  - illegal or mem_timeout is held until rst; no other exit.
- ALUOp outside EXECUTE/MEM is 11. word_op holds from DECODE until the next FETCH.
- Timeout:
  - The wait counter is cleared on entering FETCH or MEM and increments each cycle while ready is low.
  - If the counter reaches TIMEOUT_CYCLES with ready still low -> TRAP, mem_timeout=1.
  - Ready arriving in the same cycle as the limit wins: normal transition, no trap.
- Minimum latencies with ready=1 immediately, counted from FETCH entry to the next FETCH:
  - R/I: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Reset mid-operation (any state, including TRAP or mid-wait) returns to FETCH on the next cycle with no write-enable pulse. A request dropped by reset is not resumed.
- Ready inputs are ignored outside their own wait state.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode localparams (OPCODE_RTYPE etc.);
  - ALUOP_ADD/BRANCH/RTYPE/INVALID;
  - state encodings;
  - instruction-class encoding (3 bits).
- Sub-module opcode_classifier: combinational; opcode plus SUPPORT_WORD_OPS in; class, word_op and illegal out. It is reusable by a future pipelined decoder.

Test Plan:
1. Reset, then R-type 0110011, imem_ready and dmem_ready tied high -> states 0,1,2,4,0; RegWrite=1 only in cycle 4; ALUOp=10 and ALUSrc=0 in cycle 3.
2. LOAD 0000011, dmem_ready held low 3 cycles -> MEM lasts 4 cycles with dmem_req=1 and dmem_we=0; then WRITEBACK with RegWrite=1 and MemToReg=1.
3. STORE 0100011, then BRANCH 1100011 -> store: dmem_we=1 in MEM, no RegWrite; branch: branch=1 for exactly one cycle with ALUOp=01, back to FETCH.
4. opcode 0111011 with SUPPORT_WORD_OPS=0 -> TRAP with illegal=1, held 20 cycles; with SUPPORT_WORD_OPS=1 -> word_op=1, RegWrite pulse; rst then returns to FETCH with illegal=0.
5. TIMEOUT_CYCLES=4, imem_ready=0 -> TRAP and mem_timeout=1 after 4 FETCH cycles. Repeat with imem_ready rising exactly at the limit -> no trap, DECODE.
6. rst asserted in MEM mid-wait -> next cycle FETCH, dmem_req=0, no RegWrite, sticky flags 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV64 multi-cycle control unit and its opcode classifier.
package riscv_ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned CLS_W    = 3;

    localparam logic [OPCODE_W-1:0] OPCODE_RTYPE   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPCODE_ITYPE   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPCODE_LOAD    = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPCODE_STORE   = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPCODE_BRANCH  = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPCODE_RTYPE32 = 7'b0111011;
    localparam logic [OPCODE_W-1:0] OPCODE_ITYPE32 = 7'b0011011;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD     = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH  = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_INVALID = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [CLS_W-1:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_R32    = 3'd6,
        CLS_I32    = 3'd7
    } cls_e;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode-to-class decoder; word ops are illegal unless enabled.
module opcode_classifier
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_WORD_OPS = 1
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    output cls_e                cls_o,
    output logic                word_op_o,
    output logic                illegal_o
);

    localparam bit WORD_EN = (SUPPORT_WORD_OPS != 0);

    always_comb begin
        cls_o     = CLS_NONE;
        word_op_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPCODE_RTYPE:  cls_o = CLS_R;
            OPCODE_ITYPE:  cls_o = CLS_I;
            OPCODE_LOAD:   cls_o = CLS_LOAD;
            OPCODE_STORE:  cls_o = CLS_STORE;
            OPCODE_BRANCH: cls_o = CLS_BRANCH;
            OPCODE_RTYPE32: begin
                if (WORD_EN) begin
                    cls_o     = CLS_R32;
                    word_op_o = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPCODE_ITYPE32: begin
                if (WORD_EN) begin
                    cls_o     = CLS_I32;
                    word_op_o = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV64 control FSM: fetch/decode/execute/mem/writeback with
// bounded ready handshakes and sticky illegal/timeout traps.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned SUPPORT_WORD_OPS = 1,
    parameter int unsigned TIMEOUT_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic                RegWrite,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                ALUSrc,
    output logic                MemToReg,
    output logic                word_op,
    output logic                branch,
    output logic                illegal,
    output logic                mem_timeout,
    output logic [STATE_W-1:0]  state_o
);

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_LIM    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d;
    logic               word_q, word_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               tmo_q, tmo_d;

    cls_e               dec_cls;
    logic               dec_word;
    logic               dec_illegal;
    logic               limit_hit;
    logic               wait_ready;

    opcode_classifier #(
        .SUPPORT_WORD_OPS (SUPPORT_WORD_OPS)
    ) u_classifier (
        .opcode_i  (opcode),
        .cls_o     (dec_cls),
        .word_op_o (dec_word),
        .illegal_o (dec_illegal)
    );

    // Last permitted wait cycle: a low ready here means the handshake has expired.
    assign limit_hit  = TIMEOUT_EN && (wait_q == CNT_W'(CNT_LIM));
    assign wait_ready = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
    assign state_o    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NONE;
            word_q    <= 1'b0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            word_q    <= word_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        word_d    = word_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        tmo_d     = tmo_q;

        case (state_q)
            ST_FETCH, ST_MEM: begin
                if (wait_ready) begin
                    if (state_q == ST_FETCH) begin
                        state_d = ST_DECODE;
                    end else if (cls_q == CLS_LOAD) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (limit_hit) begin
                    state_d = ST_TRAP;
                    tmo_d   = 1'b1;
                end else if (TIMEOUT_EN) begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                    cls_d     = CLS_NONE;
                    word_d    = 1'b0;
                end else begin
                    state_d = ST_EXECUTE;
                    cls_d   = dec_cls;
                    word_d  = dec_word;
                end
            end
            ST_EXECUTE: begin
                case (cls_q)
                    CLS_R, CLS_R32, CLS_I, CLS_I32: state_d = ST_WRITEBACK;
                    CLS_LOAD, CLS_STORE:            state_d = ST_MEM;
                    CLS_BRANCH:                     state_d = ST_FETCH;
                    default: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase

        // Every wait window starts from zero.
        if (state_d != state_q) begin
            wait_d = '0;
        end
        if (state_d == ST_FETCH) begin
            word_d = 1'b0;
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        RegWrite    = 1'b0;
        ALUOp       = ALUOP_INVALID;
        ALUSrc      = 1'b0;
        MemToReg    = 1'b0;
        word_op     = 1'b0;
        branch      = 1'b0;
        illegal     = 1'b0;
        mem_timeout = 1'b0;

        if (!rst) begin
            illegal     = illegal_q;
            mem_timeout = tmo_q;
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                    pc_write = imem_ready;
                end
                ST_DECODE: begin
                    word_op = dec_word & ~dec_illegal;
                end
                ST_EXECUTE: begin
                    word_op = word_q;
                    case (cls_q)
                        CLS_R, CLS_R32: begin
                            ALUOp  = ALUOP_RTYPE;
                            ALUSrc = 1'b0;
                        end
                        CLS_I, CLS_I32: begin
                            ALUOp  = ALUOP_RTYPE;
                            ALUSrc = 1'b1;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            ALUOp  = ALUOP_ADD;
                            ALUSrc = 1'b1;
                        end
                        CLS_BRANCH: begin
                            ALUOp  = ALUOP_BRANCH;
                            ALUSrc = 1'b0;
                            branch = 1'b1;
                        end
                        default: ALUOp = ALUOP_INVALID;
                    endcase
                end
                ST_MEM: begin
                    // Address operands stay selected while the access is outstanding.
                    dmem_req = 1'b1;
                    dmem_we  = (cls_q == CLS_STORE);
                    ALUOp    = ALUOP_ADD;
                    ALUSrc   = 1'b1;
                    word_op  = word_q;
                end
                ST_WRITEBACK: begin
                    RegWrite = 1'b1;
                    MemToReg = (cls_q == CLS_LOAD);
                    word_op  = word_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: three control units (default, no word ops,
// 4-cycle timeout) checked cycle by cycle against per-instruction expected traces.
module tb_multicycle_control;

    localparam int NDUT = 3;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] aluop;
        logic       alu_src;
        logic       mem_to_reg;
        logic       word_op;
        logic       branch;
        logic       illegal;
        logic       mem_timeout;
    } outv_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0]       rst;
    logic [NDUT-1:0][6:0]  opcode;
    logic [NDUT-1:0]       imem_ready, dmem_ready;
    logic [NDUT-1:0]       imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write;
    logic [NDUT-1:0][1:0]  aluop;
    logic [NDUT-1:0]       alu_src, mem_to_reg, word_op, branch, illegal, mem_timeout;
    logic [NDUT-1:0][2:0]  state;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        multicycle_control #(
            .SUPPORT_WORD_OPS ((g == 1) ? 0 : 1),
            .TIMEOUT_CYCLES   ((g == 2) ? 4 : 16)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .opcode      (opcode[g]),
            .imem_ready  (imem_ready[g]),
            .dmem_ready  (dmem_ready[g]),
            .imem_req    (imem_req[g]),
            .dmem_req    (dmem_req[g]),
            .dmem_we     (dmem_we[g]),
            .ir_write    (ir_write[g]),
            .pc_write    (pc_write[g]),
            .RegWrite    (reg_write[g]),
            .ALUOp       (aluop[g]),
            .ALUSrc      (alu_src[g]),
            .MemToReg    (mem_to_reg[g]),
            .word_op     (word_op[g]),
            .branch      (branch[g]),
            .illegal     (illegal[g]),
            .mem_timeout (mem_timeout[g]),
            .state_o     (state[g])
        );
    end

    // Class codes used by the reference: 0 illegal, 1 R, 2 I, 3 load, 4 store, 5 branch.
    logic [6:0] legal_ops [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b0111011, 7'b0011011};

    int n_chk = 0;
    int n_err = 0;
    bit m_ill [NDUT];
    bit m_tmo [NDUT];

    function automatic int sup_of(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    function automatic int tmo_of(input int d);
        return (d == 2) ? 4 : 16;
    endfunction

    function automatic int classify(input logic [6:0] op, input int sup, output bit w);
        w = 1'b0;
        case (op)
            7'b0110011: return 1;
            7'b0010011: return 2;
            7'b0000011: return 3;
            7'b0100011: return 4;
            7'b1100011: return 5;
            7'b0111011: begin w = (sup != 0); return (sup != 0) ? 1 : 0; end
            7'b0011011: begin w = (sup != 0); return (sup != 0) ? 2 : 0; end
            default:    return 0;
        endcase
    endfunction

    function automatic outv_t idle_v();
        outv_t v = '0;
        v.aluop = 2'b11;
        return v;
    endfunction

    function automatic outv_t observe(input int d);
        outv_t v;
        v.imem_req    = imem_req[d];
        v.dmem_req    = dmem_req[d];
        v.dmem_we     = dmem_we[d];
        v.ir_write    = ir_write[d];
        v.pc_write    = pc_write[d];
        v.reg_write   = reg_write[d];
        v.aluop       = aluop[d];
        v.alu_src     = alu_src[d];
        v.mem_to_reg  = mem_to_reg[d];
        v.word_op     = word_op[d];
        v.branch      = branch[d];
        v.illegal     = illegal[d];
        v.mem_timeout = mem_timeout[d];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Scramble inputs the unit must ignore in the current cycle.
    task automatic noise(input int d);
        opcode[d]     = 7'($urandom);
        imem_ready[d] = 1'($urandom);
        dmem_ready[d] = 1'($urandom);
    endtask

    task automatic cyc(input int d, input int st, input outv_t e, input string tag);
        @(negedge clk);
        check($sformatf("dut%0d.%s.out", d, tag), 32'(observe(d)), 32'(e));
        if (st >= 0) check($sformatf("dut%0d.%s.state", d, tag), 32'(state[d]), 32'(st));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d, input int n);
        rst[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            noise(d);
            cyc(d, -1, idle_v(), "reset");
        end
        m_ill[d] = 1'b0;
        m_tmo[d] = 1'b0;
        rst[d]   = 1'b0;
    endtask

    task automatic hold_trap(input int d, input int n);
        outv_t e = idle_v();
        e.illegal     = m_ill[d];
        e.mem_timeout = m_tmo[d];
        for (int i = 0; i < n; i++) begin
            noise(d);
            cyc(d, 5, e, "trap");
        end
    endtask

    // One instruction: di/dd are ready delays in cycles; abort_mem>0 leaves MEM early.
    task automatic run_instr(input int d, input logic [6:0] op, input int di, input int dd,
                             input int abort_mem);
        int    t = tmo_of(d);
        int    cl;
        int    n;
        bit    w;
        bit    to;
        outv_t e;

        to = (t != 0) && (di >= t);
        n  = to ? t : di + 1;
        for (int k = 0; k < n; k++) begin
            noise(d);
            imem_ready[d] = (k >= di);
            e = idle_v();
            e.imem_req = 1'b1;
            e.ir_write = (k >= di);
            e.pc_write = (k >= di);
            cyc(d, 0, e, "fetch");
        end
        if (to) begin
            m_tmo[d] = 1'b1;
            return;
        end

        noise(d);
        opcode[d] = op;
        cl = classify(op, sup_of(d), w);
        e = idle_v();
        e.word_op = w && (cl != 0);
        cyc(d, 1, e, "decode");
        if (cl == 0) begin
            m_ill[d] = 1'b1;
            return;
        end

        noise(d);
        e = idle_v();
        e.word_op = w;
        case (cl)
            1: begin e.aluop = 2'b10; e.alu_src = 1'b0; end
            2: begin e.aluop = 2'b10; e.alu_src = 1'b1; end
            3, 4: begin e.aluop = 2'b00; e.alu_src = 1'b1; end
            default: begin e.aluop = 2'b01; e.alu_src = 1'b0; e.branch = 1'b1; end
        endcase
        cyc(d, 2, e, "execute");
        if (cl == 5) return;

        if (cl == 3 || cl == 4) begin
            to = (t != 0) && (dd >= t);
            n  = to ? t : dd + 1;
            if (abort_mem > 0) n = abort_mem;
            for (int k = 0; k < n; k++) begin
                noise(d);
                dmem_ready[d] = (abort_mem == 0) && (k >= dd);
                e = idle_v();
                e.dmem_req = 1'b1;
                e.dmem_we  = (cl == 4);
                e.aluop    = 2'b00;
                e.alu_src  = 1'b1;
                e.word_op  = w;
                cyc(d, 3, e, "mem");
            end
            if (abort_mem > 0) return;
            if (to) begin
                m_tmo[d] = 1'b1;
                return;
            end
            if (cl == 4) return;
        end

        noise(d);
        e = idle_v();
        e.reg_write  = 1'b1;
        e.mem_to_reg = (cl == 3);
        e.word_op    = w;
        cyc(d, 4, e, "writeback");
    endtask

    task automatic recover(input int d);
        if (m_ill[d] || m_tmo[d]) begin
            hold_trap(d, 3);
            do_reset(d, 1 + $urandom_range(0, 1));
        end
    endtask

    task automatic random_block(input int d, input int count);
        logic [6:0] op;
        int di, dd, t;
        t = tmo_of(d);
        for (int i = 0; i < count; i++) begin
            op = legal_ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            di = ($urandom_range(0, 9) == 0) ? $urandom_range(t - 1, t + 2) : $urandom_range(0, 5);
            dd = ($urandom_range(0, 9) == 0) ? $urandom_range(t - 1, t + 2) : $urandom_range(0, 5);
            run_instr(d, op, di, dd, 0);
            recover(d);
        end
    endtask

    initial begin
        rst        = '1;
        opcode     = '0;
        imem_ready = '0;
        dmem_ready = '0;
        @(posedge clk);
        #1;

        // Default configuration: directed sequences then random traffic.
        do_reset(0, 2);
        run_instr(0, 7'b0110011, 0, 0, 0);
        run_instr(0, 7'b0000011, 0, 3, 0);
        run_instr(0, 7'b0100011, 0, 0, 0);
        run_instr(0, 7'b1100011, 0, 0, 0);
        run_instr(0, 7'b0111011, 0, 0, 0);
        run_instr(0, 7'b0011011, 2, 0, 0);
        run_instr(0, 7'b0000011, 1, 15, 0);
        run_instr(0, 7'b0000011, 0, 40, 3);
        do_reset(0, 1);
        run_instr(0, 7'b0010011, 0, 0, 0);
        random_block(0, 25);
        rst[0] = 1'b1;

        // Word ops disabled: illegal trap held, then cleared by reset.
        do_reset(1, 1);
        run_instr(1, 7'b0111011, 0, 0, 0);
        hold_trap(1, 20);
        do_reset(1, 1);
        run_instr(1, 7'b0110011, 0, 0, 0);
        run_instr(1, 7'b1111111, 0, 0, 0);
        recover(1);
        random_block(1, 25);
        rst[1] = 1'b1;

        // Four-cycle timeout: fetch expiry, ready exactly at the limit, MEM expiry.
        do_reset(2, 1);
        run_instr(2, 7'b0110011, 100, 0, 0);
        hold_trap(2, 5);
        do_reset(2, 1);
        run_instr(2, 7'b0110011, 3, 0, 0);
        run_instr(2, 7'b0100011, 0, 3, 0);
        run_instr(2, 7'b0000011, 0, 4, 0);
        recover(2);
        random_block(2, 25);
        rst[2] = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
